ad_su_checker: RTL and testbench

AD_SU_CHECKER -- requirements
Module: ad_su_checker

---
 rtl/ad_su_checker_if.sv | 34 +++
 rtl/ad_su_checker.sv | 157 +++++++++++++++
 tb/tb_ad_su_checker.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/ad_su_checker_if.sv
// ============================================================================
// Module   : ad_su_checker_if
// Brief    : Operand/result and status bundle between the sweep checker and
//            the 5-bit adder/subtractor under test.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ad_su_checker_if;
    logic        start;
    logic [4:0]  a;
    logic [4:0]  b;
    logic        cin;
    logic [4:0]  s;
    logic        v;
    logic        busy;
    logic        done;
    logic        pass;
    logic [11:0] err_cnt;
    logic [10:0] first_fail;
    logic        first_fail_vld;

    modport master (
        input  start, s, v,
        output a, b, cin, busy, done, pass, err_cnt, first_fail, first_fail_vld
    );

    modport slave (
        output start, s, v,
        input  a, b, cin, busy, done, pass, err_cnt, first_fail, first_fail_vld
    );
endinterface

`default_nettype wire

// File: rtl/ad_su_checker.sv
// ============================================================================
// Module   : ad_su_checker
// Brief    : Exhaustive add/subtract sweep of an external 5-bit adder, counting
//            mismatches and recording the first failing vector.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ad_su_checker #(
    parameter int SETTLE = 1
) (
    input  wire logic          clk,
    input  wire logic          rst,
    ad_su_checker_if.master    bus
);

    localparam logic [10:0] C_LAST_IDX  = 11'd2047;
    localparam logic [3:0]  C_WAIT_LAST = (SETTLE > 1) ? 4'(SETTLE - 2) : 4'd0;

    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_APPLY       = 3'd1,
        S_SETTLE_WAIT = 3'd2,
        S_CHECK       = 3'd3,
        S_DONE        = 3'd4
    } state_t;

    state_t      r_state;
    logic [10:0] r_idx;
    logic [4:0]  r_a;
    logic [4:0]  r_b;
    logic        r_cin;
    logic [3:0]  r_wait;
    logic        r_busy;
    logic        r_done;
    logic        r_pass;
    logic [11:0] r_err_cnt;
    logic [10:0] r_first_fail;
    logic        r_first_fail_vld;
    logic        r_chk_vld;
    logic        r_chk_mis;
    logic [10:0] r_chk_vec;
    logic        r_fin;

    logic [4:0]  w_b_op;
    logic [5:0]  w_sum;
    logic [4:0]  w_s_exp;
    logic        w_v_exp;
    logic        w_mismatch;
    logic        w_acc;
    logic [11:0] w_err_next;

    // Subtraction is a + ~b + 1, so one adder and one overflow rule cover both modes.
    assign w_b_op     = r_cin ? ~r_b : r_b;
    assign w_sum      = {1'b0, r_a} + {1'b0, w_b_op} + {5'd0, r_cin};
    assign w_s_exp    = w_sum[4:0];
    assign w_v_exp    = (r_a[4] == w_b_op[4]) & (w_s_exp[4] != r_a[4]);
    assign w_mismatch = (bus.s != w_s_exp) | (bus.v != w_v_exp);

    // Compare result is registered and accumulated one cycle later.
    assign w_acc      = r_chk_vld & r_chk_mis;
    assign w_err_next = (w_acc && (r_err_cnt != 12'hFFF)) ? r_err_cnt + 12'd1 : r_err_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state          <= S_IDLE;
            r_idx            <= 11'd0;
            r_a              <= 5'd0;
            r_b              <= 5'd0;
            r_cin            <= 1'b0;
            r_wait           <= 4'd0;
            r_busy           <= 1'b0;
            r_done           <= 1'b0;
            r_pass           <= 1'b0;
            r_err_cnt        <= 12'd0;
            r_first_fail     <= 11'd0;
            r_first_fail_vld <= 1'b0;
            r_chk_vld        <= 1'b0;
            r_chk_mis        <= 1'b0;
            r_chk_vec        <= 11'd0;
            r_fin            <= 1'b0;
        end else begin
            r_chk_vld <= 1'b0;
            if (w_acc) begin
                r_err_cnt <= w_err_next;
                if (!r_first_fail_vld) begin
                    r_first_fail     <= r_chk_vec;
                    r_first_fail_vld <= 1'b1;
                end
            end

            case (r_state)
                S_IDLE, S_DONE: begin
                    if (r_fin) begin
                        r_fin  <= 1'b0;
                        r_busy <= 1'b0;
                        r_done <= 1'b1;
                        r_pass <= (w_err_next == 12'd0);
                    end else if (bus.start) begin
                        r_idx            <= 11'd0;
                        r_err_cnt        <= 12'd0;
                        r_first_fail     <= 11'd0;
                        r_first_fail_vld <= 1'b0;
                        r_done           <= 1'b0;
                        r_pass           <= 1'b0;
                        r_busy           <= 1'b1;
                        r_state          <= S_APPLY;
                    end
                end

                S_APPLY: begin
                    r_cin   <= r_idx[10];
                    r_a     <= r_idx[9:5];
                    r_b     <= r_idx[4:0];
                    r_wait  <= 4'd0;
                    r_state <= (SETTLE == 1) ? S_CHECK : S_SETTLE_WAIT;
                end

                S_SETTLE_WAIT: begin
                    if (r_wait == C_WAIT_LAST) begin
                        r_state <= S_CHECK;
                    end else begin
                        r_wait <= r_wait + 4'd1;
                    end
                end

                S_CHECK: begin
                    r_chk_vld <= 1'b1;
                    r_chk_mis <= w_mismatch;
                    r_chk_vec <= {r_cin, r_a, r_b};
                    if (r_idx == C_LAST_IDX) begin
                        r_fin   <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_idx   <= r_idx + 11'd1;
                        r_state <= S_APPLY;
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.a              = r_a;
    assign bus.b              = r_b;
    assign bus.cin            = r_cin;
    assign bus.busy           = r_busy;
    assign bus.done           = r_done;
    assign bus.pass           = r_pass;
    assign bus.err_cnt        = r_err_cnt;
    assign bus.first_fail     = r_first_fail;
    assign bus.first_fail_vld = r_first_fail_vld;

endmodule

`default_nettype wire

// File: tb/tb_ad_su_checker.sv
// ============================================================================
// Module   : tb_ad_su_checker
// Brief    : Self-checking bench for ad_su_checker with fault-injecting
//            adder models and a signed-arithmetic reference.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ad_su_checker;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ad_su_checker_if if1 ();
    ad_su_checker_if if3 ();

    ad_su_checker #(.SETTLE(1)) u_dut1 (.clk(clk), .rst(rst), .bus(if1.master));
    ad_su_checker #(.SETTLE(3)) u_dut3 (.clk(clk), .rst(rst), .bus(if3.master));

    int   n_assert = 0;
    int   n_fail   = 0;
    int   mode     = 0;
    int   kbit     = 0;
    logic kval     = 1'b0;

    // External adder/subtractor model: 6-bit sign-extended arithmetic plus a fault.
    function automatic logic [5:0] dev(input logic [10:0] vec, input int md,
                                       input int k, input logic val);
        logic [5:0] x, y, r;
        logic [4:0] s;
        logic       ov;
        x  = {vec[9], vec[9:5]};
        y  = {vec[4], vec[4:0]};
        r  = vec[10] ? x - y : x + y;
        s  = r[4:0];
        ov = r[5] ^ r[4];
        if (md == 1) s[k] = val;
        if (md == 2) ov = ~ov;
        return {ov, s};
    endfunction

    always_comb {if1.v, if1.s} = dev({if1.cin, if1.a, if1.b}, mode, kbit, kval);

    logic [10:0] p1 = 11'd0;
    logic [10:0] p2 = 11'd0;
    always_ff @(posedge clk) begin
        p1 <= {if3.cin, if3.a, if3.b};
        p2 <= p1;
    end
    always_comb {if3.v, if3.s} = dev(p2, 0, 0, 1'b0);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: integer two's-complement result, out-of-range means overflow.
    task automatic ref_sweep(input int md, input int k, input logic val,
                             output int err, output int first);
        err   = 0;
        first = -1;
        for (int i = 0; i < 2048; i++) begin
            int av, bv, sa, sb, r, rs, ds;
            bit rv, dv;
            av = (i >> 5) & 31;
            bv = i & 31;
            sa = (av >= 16) ? av - 32 : av;
            sb = (bv >= 16) ? bv - 32 : bv;
            r  = (i >= 1024) ? sa - sb : sa + sb;
            rv = (r > 15) || (r < -16);
            rs = r & 31;
            ds = rs;
            if (md == 1) ds = val ? (rs | (1 << k)) : (rs & ~(1 << k));
            dv = (md == 2) ? !rv : rv;
            if ((ds != rs) || (dv != rv)) begin
                err++;
                if (first < 0) first = i;
            end
        end
    endtask

    task automatic set_start(input int which, input logic val);
        if (which == 1) if1.start = val;
        else            if3.start = val;
    endtask

    function automatic logic [10:0] cur_vec(input int which);
        return (which == 1) ? {if1.cin, if1.a, if1.b} : {if3.cin, if3.a, if3.b};
    endfunction

    function automatic logic cur_done(input int which);
        return (which == 1) ? if1.done : if3.done;
    endfunction

    // inj: 0 none, 1 reset when vector inj_at appears, 2 extra start at inj_at.
    task automatic sweep(input int which, input int inj, input int inj_at, output int edges);
        bit injected;
        injected = 0;
        edges    = -1;
        @(negedge clk);
        set_start(which, 1'b1);
        @(posedge clk); #1;
        set_start(which, 1'b0);
        chk("start_busy", (which == 1) ? if1.busy : if3.busy, 1);
        chk("start_clear", {cur_done(which), (which == 1) ? if1.err_cnt : if3.err_cnt}, 0);
        for (int n = 1; n <= 9000; n++) begin
            @(posedge clk); #1;
            if (inj != 0 && !injected && cur_vec(which) == 11'(inj_at)) begin
                injected = 1;
                if (inj == 1) begin
                    rst = 1'b1;
                    @(posedge clk); #1;
                    rst = 1'b0;
                    chk("rstmid_ops", {if1.cin, if1.a, if1.b}, 0);
                    chk("rstmid_flags", {if1.busy, if1.done, if1.pass, if1.first_fail_vld}, 0);
                    chk("rstmid_err", if1.err_cnt, 0);
                    chk("rstmid_ff", if1.first_fail, 0);
                    repeat (4) @(posedge clk);
                    #1;
                    chk("rstmid_noresume", {if1.busy, if1.cin, if1.a, if1.b}, 0);
                    edges = 0;
                    return;
                end else begin
                    set_start(which, 1'b1);
                    @(posedge clk); #1;
                    set_start(which, 1'b0);
                    n++;
                end
            end
            if (cur_done(which)) begin
                edges = n;
                break;
            end
        end
    endtask

    task automatic check_result(input string tag);
        int err, first;
        ref_sweep(mode, kbit, kval, err, first);
        chk({tag, "_err"},  if1.err_cnt, err);
        chk({tag, "_pass"}, if1.pass, (err == 0) ? 1 : 0);
        chk({tag, "_ffv"},  if1.first_fail_vld, (first >= 0) ? 1 : 0);
        chk({tag, "_ff"},   if1.first_fail, (first >= 0) ? first : 0);
        chk({tag, "_hold"}, {if1.busy, if1.cin, if1.a, if1.b}, 12'h7FF);
    endtask

    initial begin
        int edges;
        if1.start = 1'b0;
        if3.start = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ops", {if1.cin, if1.a, if1.b}, 0);
        chk("rst_flags", {if1.busy, if1.done, if1.pass, if1.first_fail_vld}, 0);
        chk("rst_err", if1.err_cnt, 0);
        chk("rst_ff", if1.first_fail, 0);
        rst = 1'b0;

        mode = 0;
        sweep(1, 0, 0, edges);
        chk("clean_edges", edges, 4097);
        check_result("clean");

        mode = 1; kbit = 0; kval = 1'b0;
        sweep(1, 0, 0, edges);
        chk("s0stuck_edges", edges, 4097);
        chk("s0stuck_cnt", {if1.err_cnt, if1.first_fail}, {12'd1024, 11'h001});
        check_result("s0stuck");

        mode = 2;
        sweep(1, 0, 0, edges);
        chk("vinv_cnt", {if1.err_cnt, if1.first_fail}, {12'd2048, 11'h000});
        check_result("vinv");

        mode = 1; kbit = $urandom_range(0, 4); kval = 1'($urandom_range(0, 1));
        sweep(1, 0, 0, edges);
        chk("rndstuck_edges", edges, 4097);
        check_result("rndstuck");

        sweep(1, 0, 0, edges);
        chk("repeat_edges", edges, 4097);
        check_result("repeat");

        mode = 1; kbit = 0; kval = 1'b0;
        sweep(1, 1, 100, edges);
        chk("rst100_taken", edges, 0);
        mode = 0;
        sweep(1, 0, 0, edges);
        chk("after_rst_edges", edges, 4097);
        check_result("after_rst");

        mode = 1; kbit = $urandom_range(0, 4); kval = 1'b1;
        sweep(1, 1, $urandom_range(1, 2000), edges);
        chk("rndrst_taken", edges, 0);
        sweep(1, 2, 500, edges);
        chk("restart_edges", edges, 4097);
        check_result("restart");

        sweep(3, 0, 0, edges);
        chk("lag_edges", edges, 8193);
        chk("lag_err", if3.err_cnt, 0);
        chk("lag_pass", {if3.pass, if3.first_fail_vld, if3.busy}, 3'b100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
